// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for a 5-stage pipeline: stalls, redirects,
// flushes, ALU forwarding selects and a data-memory wait-state freeze.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 0,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_is_load,
  input  logic              id_is_store,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        pc_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0]        LAT    = 4'(MEM_LAT);
  localparam logic              FWD_ON = (FWD_EN != 0);
  localparam logic [REG_AW-1:0] R0     = {REG_AW{1'b0}};

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic              st;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ex_stage_t;

  // MEM and WB are only ever consulted as forwarding/dependency producers.
  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
  } dst_stage_t;

  localparam ex_stage_t  EX_BUBBLE  = '{v: 1'b0, wr: 1'b0, ld: 1'b0, st: 1'b0,
                                         use_rs: 1'b0, use_rt: 1'b0,
                                         rd: R0, rs: R0, rt: R0};
  localparam dst_stage_t DST_BUBBLE = '{v: 1'b0, wr: 1'b0, rd: R0};

  ex_stage_t         ex_q, ex_d, id_stage;
  dst_stage_t        mem_q, mem_d, wb_q, wb_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              frozen, branch, load_use, any_dep, stall, jump;

  function automatic logic dst_hit(logic v, logic wr, logic [REG_AW-1:0] rd,
                                   logic [REG_AW-1:0] src, logic use_src);
    return v & wr & (rd != R0) & (rd == src) & use_src;
  endfunction

  function automatic logic [1:0] fwd_sel(dst_stage_t mem_s, dst_stage_t wb_s,
                                         logic [REG_AW-1:0] src, logic use_src);
    logic [1:0] sel;
    if (dst_hit(mem_s.v, mem_s.wr, mem_s.rd, src, use_src)) begin
      sel = 2'd1;
    end else if (dst_hit(wb_s.v, wb_s.wr, wb_s.rd, src, use_src)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Pack the ID-stage inputs into the shadow record format.
  always_comb begin
    id_stage = '{v: id_valid, wr: id_wr_en, ld: id_is_load, st: id_is_store,
                 use_rs: id_use_rs, use_rt: id_use_rt,
                 rd: id_wr_reg, rs: id_rs, rt: id_rt};
  end

  // Hazard detection against the shadow stages.
  always_comb begin
    frozen   = (wcnt_q != 4'd0);
    branch   = ex_q.v & ex_branch_taken;
    load_use = ex_q.ld &
               (dst_hit(ex_q.v, ex_q.wr, ex_q.rd, id_rs, id_use_rs) |
                dst_hit(ex_q.v, ex_q.wr, ex_q.rd, id_rt, id_use_rt));
    any_dep  = dst_hit(ex_q.v,  ex_q.wr,  ex_q.rd,  id_rs, id_use_rs) |
               dst_hit(ex_q.v,  ex_q.wr,  ex_q.rd,  id_rt, id_use_rt) |
               dst_hit(mem_q.v, mem_q.wr, mem_q.rd, id_rs, id_use_rs) |
               dst_hit(mem_q.v, mem_q.wr, mem_q.rd, id_rt, id_use_rt) |
               dst_hit(wb_q.v,  wb_q.wr,  wb_q.rd,  id_rs, id_use_rs) |
               dst_hit(wb_q.v,  wb_q.wr,  wb_q.rd,  id_rt, id_use_rt);
    stall    = load_use | (~FWD_ON & any_dep);
    jump     = id_valid & id_jump;
  end

  // Pipeline control with priority reset > freeze > branch > stall > jump.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    pipe_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel     = 2'd0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (frozen) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (branch) begin
      pc_sel     = 2'd1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (jump) begin
      pc_sel     = 2'd2;
      ifid_flush = 1'b1;
    end else begin
      pc_sel     = 2'd0;
    end
  end

  // ALU operand forwarding for the instruction currently in EX.
  always_comb begin
    if (rst || !FWD_ON) begin
      fwd_a = 2'd0;
      fwd_b = 2'd0;
    end else begin
      fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.use_rs);
      fwd_b = fwd_sel(mem_q, wb_q, ex_q.rt, ex_q.use_rt);
    end
  end

  // Next state of the shadow pipeline, wait counter and stall counter.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (pipe_en) begin
      ex_d  = idex_flush ? EX_BUBBLE : id_stage;
      mem_d = '{v: ex_q.v, wr: ex_q.wr, rd: ex_q.rd};
      wb_d  = mem_q;
    end else begin
      ex_d  = ex_q;
    end

    if (frozen) begin
      wcnt_d = wcnt_q - 4'd1;
    end else if (pipe_en && ex_q.v && (ex_q.ld || ex_q.st)) begin
      wcnt_d = LAT;
    end else begin
      wcnt_d = 4'd0;
    end

    if (!pc_en) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset; reset also aborts a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= EX_BUBBLE;
      mem_q       <= DST_BUBBLE;
      wb_q        <= DST_BUBBLE;
      wcnt_q      <= 4'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameter variants share one input stream
// and are compared against an instruction-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_store, id_jump;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       ex_branch_taken;

  logic       o_pc_en[N], o_ifid_en[N], o_ifid_flush[N], o_idex_flush[N], o_pipe_en[N];
  logic [1:0] o_fwd_a[N], o_fwd_b[N], o_pc_sel[N];
  logic [31:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(0), .FWD_EN(1), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_en(o_pc_en[0]), .ifid_en(o_ifid_en[0]), .ifid_flush(o_ifid_flush[0]),
    .idex_flush(o_idex_flush[0]), .pipe_en(o_pipe_en[0]), .fwd_a(o_fwd_a[0]),
    .fwd_b(o_fwd_b[0]), .pc_sel(o_pc_sel[0]), .stall_cnt(cnt0));

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .FWD_EN(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_en(o_pc_en[1]), .ifid_en(o_ifid_en[1]), .ifid_flush(o_ifid_flush[1]),
    .idex_flush(o_idex_flush[1]), .pipe_en(o_pipe_en[1]), .fwd_a(o_fwd_a[1]),
    .fwd_b(o_fwd_b[1]), .pc_sel(o_pc_sel[1]), .stall_cnt(cnt1));

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(2), .FWD_EN(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_en(o_pc_en[2]), .ifid_en(o_ifid_en[2]), .ifid_flush(o_ifid_flush[2]),
    .idex_flush(o_idex_flush[2]), .pipe_en(o_pipe_en[2]), .fwd_a(o_fwd_a[2]),
    .fwd_b(o_fwd_b[2]), .pc_sel(o_pc_sel[2]), .stall_cnt(cnt2));

  // Reference model: an in-flight instruction list per variant.
  typedef struct { bit v, wr, ld, st, urs, urt; int rd, rs, rt; } ins_t;
  typedef struct { bit pc_en, ifid_en, ifid_flush, idex_flush, pipe_en; int fwd_a, fwd_b, pc_sel; } exp_t;

  ins_t   pipe_m[N][3];          // [variant][0=EX,1=MEM,2=WB]
  int     hold_m[N];
  longint cnt_m[N];
  int     lat_p[N] = '{0, 3, 2};
  bit     fwd_p[N] = '{1'b1, 1'b1, 1'b0};
  longint mod_p[N] = '{64'd4294967296, 64'd4294967296, 64'd16};

  exp_t   exp_s[N];
  ins_t   id_s;
  bit     rst_s;

  function automatic bit hits(ins_t s, int src, bit use_it);
    return s.v && s.wr && (s.rd != 0) && (s.rd == src) && use_it;
  endfunction

  function automatic ins_t cur_id();
    ins_t r;
    r.v = id_valid; r.wr = id_wr_en; r.ld = id_is_load; r.st = id_is_store;
    r.urs = id_use_rs; r.urt = id_use_rt;
    r.rd = int'(id_wr_reg); r.rs = int'(id_rs); r.rt = int'(id_rt);
    return r;
  endfunction

  function automatic exp_t predict(int k);
    exp_t e;
    ins_t id = cur_id();
    ins_t ex = pipe_m[k][0];
    bit dep = 1'b0;
    bit lu;
    e = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
          pipe_en: 1'b1, fwd_a: 0, fwd_b: 0, pc_sel: 0};
    if (rst) begin
      e.pc_en = 1'b0; e.ifid_en = 1'b0; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      return e;
    end
    if (fwd_p[k]) begin
      e.fwd_a = hits(pipe_m[k][1], ex.rs, ex.urs) ? 1 : (hits(pipe_m[k][2], ex.rs, ex.urs) ? 2 : 0);
      e.fwd_b = hits(pipe_m[k][1], ex.rt, ex.urt) ? 1 : (hits(pipe_m[k][2], ex.rt, ex.urt) ? 2 : 0);
    end
    for (int s = 0; s < 3; s++)
      dep |= hits(pipe_m[k][s], id.rs, id.urs) || hits(pipe_m[k][s], id.rt, id.urt);
    lu = ex.ld && (hits(ex, id.rs, id.urs) || hits(ex, id.rt, id.urt));
    if (hold_m[k] > 0) begin
      e.pc_en = 1'b0; e.ifid_en = 1'b0; e.pipe_en = 1'b0;
    end else if (ex.v && ex_branch_taken) begin
      e.pc_sel = 1; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
    end else if (lu || (!fwd_p[k] && dep)) begin
      e.pc_en = 1'b0; e.ifid_en = 1'b0; e.idex_flush = 1'b1;
    end else if (id_valid && id_jump) begin
      e.pc_sel = 2; e.ifid_flush = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [63:0] cnt_obs(int k);
    if (k == 0) return 64'(cnt0);
    else if (k == 1) return 64'(cnt1);
    else return 64'(cnt2);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Let inputs settle, predict every variant and compare all outputs.
  task automatic settle();
    #1;
    id_s  = cur_id();
    rst_s = rst;
    for (int k = 0; k < N; k++) begin
      exp_s[k] = predict(k);
      chk($sformatf("u%0d.pc_en", k),      64'(o_pc_en[k]),      64'(exp_s[k].pc_en));
      chk($sformatf("u%0d.ifid_en", k),    64'(o_ifid_en[k]),    64'(exp_s[k].ifid_en));
      chk($sformatf("u%0d.ifid_flush", k), 64'(o_ifid_flush[k]), 64'(exp_s[k].ifid_flush));
      chk($sformatf("u%0d.idex_flush", k), 64'(o_idex_flush[k]), 64'(exp_s[k].idex_flush));
      chk($sformatf("u%0d.pipe_en", k),    64'(o_pipe_en[k]),    64'(exp_s[k].pipe_en));
      chk($sformatf("u%0d.fwd_a", k),      64'(o_fwd_a[k]),      64'(exp_s[k].fwd_a));
      chk($sformatf("u%0d.fwd_b", k),      64'(o_fwd_b[k]),      64'(exp_s[k].fwd_b));
      chk($sformatf("u%0d.pc_sel", k),     64'(o_pc_sel[k]),     64'(exp_s[k].pc_sel));
      chk($sformatf("u%0d.stall_cnt", k),  cnt_obs(k),           64'(cnt_m[k]));
    end
  endtask

  // Clock edge: move the model's instructions along, then return to mid-cycle.
  task automatic advance();
    ins_t bubble;
    bubble = '{default: 0};
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (rst_s) begin
        for (int s = 0; s < 3; s++) pipe_m[k][s] = bubble;
        hold_m[k] = 0;
        cnt_m[k]  = 0;
      end else begin
        if (!exp_s[k].pc_en) cnt_m[k] = (cnt_m[k] + 1) % mod_p[k];
        if (hold_m[k] > 0) begin
          hold_m[k]--;
        end else if (exp_s[k].pipe_en) begin
          if (pipe_m[k][0].v && (pipe_m[k][0].ld || pipe_m[k][0].st)) hold_m[k] = lat_p[k];
          pipe_m[k][2] = pipe_m[k][1];
          pipe_m[k][1] = pipe_m[k][0];
          pipe_m[k][0] = exp_s[k].idex_flush ? bubble : id_s;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_id(bit v, int rd, bit wr, int rs, bit urs, int rt, bit urt,
                        bit ld, bit st, bit jmp);
    id_valid = v; id_wr_reg = 5'(rd); id_wr_en = wr; id_rs = 5'(rs); id_use_rs = urs;
    id_rt = 5'(rt); id_use_rt = urt; id_is_load = ld; id_is_store = st; id_jump = jmp;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; nop(); ex_branch_taken = 1'b0;
    settle(); advance();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < 3; s++) pipe_m[k][s] = '{default: 0};
      hold_m[k] = 0; cnt_m[k] = 0;
    end
    @(negedge clk);
    rst = 1'b1; nop(); ex_branch_taken = 1'b0;
    settle(); advance();
    settle();
    chk("rst.pc_en", 64'(o_pc_en[0]), 64'd0);
    chk("rst.ifid_flush", 64'(o_ifid_flush[0]), 64'd1);
    advance();
    rst = 1'b0;

    // Load-use: lw r2 then add r3,r2,r4.
    set_id(1, 2, 1, 1, 1, 0, 0, 1, 0, 0); settle(); advance();
    set_id(1, 3, 1, 2, 1, 4, 1, 0, 0, 0); settle();
    chk("lu.pc_en", 64'(o_pc_en[0]), 64'd0);
    chk("lu.idex_flush", 64'(o_idex_flush[0]), 64'd1);
    advance();
    settle();
    chk("lu.release", 64'(o_pc_en[0]), 64'd1);
    advance();
    nop(); settle();
    chk("lu.fwd_a", 64'(o_fwd_a[0]), 64'd2);
    chk("lu.cnt", 64'(cnt0), 64'd1);
    advance();

    // Forwarding priority: MEM over WB, then WB alone, then r0.
    set_id(1, 2, 1, 3, 0, 4, 0, 0, 0, 0); settle(); advance();
    set_id(1, 2, 1, 5, 0, 6, 0, 0, 0, 0); settle(); advance();
    set_id(1, 7, 1, 2, 1, 2, 1, 0, 0, 0); settle(); advance();
    nop(); settle();
    chk("fwd.mem_a", 64'(o_fwd_a[0]), 64'd1);
    chk("fwd.mem_b", 64'(o_fwd_b[0]), 64'd1);
    advance();
    set_id(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    nop(); settle(); advance();
    set_id(1, 7, 1, 2, 1, 0, 0, 0, 0, 0); settle(); advance();
    nop(); settle();
    chk("fwd.wb_a", 64'(o_fwd_a[0]), 64'd2);
    advance();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    set_id(1, 7, 1, 0, 1, 0, 1, 0, 0, 0); settle(); advance();
    nop(); settle();
    chk("fwd.r0_a", 64'(o_fwd_a[0]), 64'd0);
    chk("fwd.r0_b", 64'(o_fwd_b[0]), 64'd0);
    advance();

    // Taken branch beats a pending load-use stall.
    set_id(1, 6, 1, 0, 0, 0, 0, 1, 0, 0); settle(); advance();
    set_id(1, 9, 1, 6, 1, 0, 0, 0, 0, 0); ex_branch_taken = 1'b1; settle();
    chk("br.pc_sel", 64'(o_pc_sel[0]), 64'd1);
    chk("br.pc_en", 64'(o_pc_en[0]), 64'd1);
    chk("br.idex_flush", 64'(o_idex_flush[0]), 64'd1);
    advance();
    ex_branch_taken = 1'b0; nop(); settle(); advance();

    // Jump with no hazard, then a jump held back by a load-use stall.
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
    chk("j.pc_sel", 64'(o_pc_sel[0]), 64'd2);
    chk("j.ifid_flush", 64'(o_ifid_flush[0]), 64'd1);
    advance();
    nop(); settle();
    chk("j.one_cycle", 64'(o_pc_sel[0]), 64'd0);
    advance();
    set_id(1, 8, 1, 0, 0, 0, 0, 1, 0, 0); settle(); advance();
    set_id(1, 0, 0, 8, 1, 0, 0, 0, 0, 1); settle();
    chk("jstall.pc_sel", 64'(o_pc_sel[0]), 64'd0);
    chk("jstall.pc_en", 64'(o_pc_en[0]), 64'd0);
    advance();
    settle();
    chk("jstall.taken", 64'(o_pc_sel[0]), 64'd2);
    advance();

    // Store wait-states on u1 (MEM_LAT=3), branch waits behind the freeze.
    do_reset();
    set_id(1, 0, 0, 1, 1, 2, 1, 0, 1, 0); settle(); advance();
    set_id(1, 0, 0, 3, 1, 4, 1, 0, 0, 0); settle(); advance();
    nop(); ex_branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("frz.pipe_en", 64'(o_pipe_en[1]), 64'd0);
      chk("frz.pc_en", 64'(o_pc_en[1]), 64'd0);
      advance();
    end
    settle();
    chk("frz.br_after", 64'(o_pc_sel[1]), 64'd1);
    chk("frz.cnt", 64'(cnt1), 64'd3);
    advance();
    ex_branch_taken = 1'b0;

    // No-forwarding stall on u2, then reset in the middle of a freeze.
    do_reset();
    set_id(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); settle(); advance();
    nop(); settle(); advance();
    settle(); advance();
    set_id(1, 6, 1, 5, 1, 0, 0, 0, 0, 0); settle();
    chk("nofwd.stall", 64'(o_pc_en[2]), 64'd0);
    chk("nofwd.flush", 64'(o_idex_flush[2]), 64'd1);
    advance();
    nop(); settle(); advance();
    set_id(1, 1, 1, 0, 0, 0, 0, 1, 0, 0); settle(); advance();
    nop(); settle(); advance();
    settle();
    chk("rstfrz.frozen", 64'(o_pipe_en[2]), 64'd0);
    advance();
    rst = 1'b1; settle(); advance();
    rst = 1'b0; settle();
    chk("rstfrz.pc_en", 64'(o_pc_en[2]), 64'd1);
    chk("rstfrz.pipe_en", 64'(o_pipe_en[2]), 64'd1);
    chk("rstfrz.ifid_flush", 64'(o_ifid_flush[2]), 64'd0);
    chk("rstfrz.cnt2", 64'(cnt2), 64'd0);
    chk("rstfrz.cnt1", 64'(cnt1), 64'd0);
    advance();

    // Random traffic over a small register set to provoke collisions.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
